// File: rtl/sar_search_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sar_search_pkg
// Description : Shared types and constants for the successive-approximation
//               search controller: FSM state encoding, bit positions inside
//               the packed {agb, aeb, alb} flag vector, and the three legal
//               one-hot flag encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package sar_search_pkg;

    // FSM states. ST_WAIT is only reachable when SAR_CMP_PIPE_EN is defined.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRIAL = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bit positions inside the packed flag vector {agb, aeb, alb}.
    localparam int AGB = 2;
    localparam int AEB = 1;
    localparam int ALB = 0;

    // Legal (one-hot) flag encodings.
    localparam logic [2:0] c_flag_gt = 3'b100;
    localparam logic [2:0] c_flag_eq = 3'b010;
    localparam logic [2:0] c_flag_lt = 3'b001;

endpackage : sar_search_pkg
`default_nettype wire

// File: rtl/sar_flag_check.sv
`default_nettype none
// ============================================================================
// Module      : sar_flag_check
// Description : Combinational one-hot check of the comparator flag vector.
//               A well-behaved comparator asserts exactly one of agb/aeb/alb;
//               anything else (none, or more than one) is reported illegal.
// Ports       : flags   in  3 : packed {agb, aeb, alb}
//               flag_ok out 1 : 1 when flags is one of the legal encodings
// Revision    : 1.0 - initial release
// ============================================================================
module sar_flag_check
    import sar_search_pkg::*;
(
    input  logic [2:0] flags,
    output logic       flag_ok
);

    always_comb begin
        flag_ok = (flags == c_flag_gt) ||
                  (flags == c_flag_eq) ||
                  (flags == c_flag_lt);
    end

endmodule : sar_flag_check
`default_nettype wire

// File: rtl/sar_search.sv
`default_nettype none
// ============================================================================
// Module      : sar_search
// Description : Successive-approximation controller for a WIDTH-bit magnitude
//               comparator. Recovers the unknown value on comparator input 'a'
//               by driving trial values on input 'b', one bit per decision,
//               MSB first, with early exit on equality.
//
// Optional    : SAR_CMP_PIPE_EN - comparator output is registered; every trial
//               is held for a TRIAL cycle plus a WAIT cycle and the flags are
//               sampled at the end of WAIT (2 cycles per bit).
//
// Ports       : clk    in  1     : clock, rising edge
//               rst_n  in  1     : asynchronous active-low reset
//               start  in  1     : begin a search (sampled in IDLE only)
//               agb    in  1     : comparator flag, T >  trial
//               aeb    in  1     : comparator flag, T == trial
//               alb    in  1     : comparator flag, T <  trial
//               trial  out WIDTH : value for comparator input 'b'
//               busy   out 1     : search in progress
//               done   out 1     : one-cycle pulse, result final
//               result out WIDTH : recovered value, held until next search
//               err    out 1     : one-cycle pulse with done on illegal flags
// Revision    : 1.0 - initial release
// ============================================================================
module sar_search
    import sar_search_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             agb,
    input  logic             aeb,
    input  logic             alb,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [IDX_W-1:0]  r_idx;       // bit currently under test
    logic [WIDTH-1:0]  r_partial;   // bits already decided (lower bits zero)
    logic [WIDTH-1:0]  r_result;
    logic              r_err;

    logic [2:0]        w_flags;
    logic              w_flag_ok;
    logic [WIDTH-1:0]  w_bit;
    logic [WIDTH-1:0]  w_trial;
    logic              w_sample;    // flags are consumed at the coming edge
    logic              w_last;
    logic              w_finish;    // this decision ends the search

    assign w_flags = {agb, aeb, alb};

    sar_flag_check u_flag_check (
        .flags   (w_flags),
        .flag_ok (w_flag_ok)
    );

    // r_partial only holds bits above r_idx, so OR-ing in the test bit never
    // carries and the trial stays within WIDTH bits.
    assign w_bit   = WIDTH'(1) << r_idx;
    assign w_trial = r_partial | w_bit;
    assign w_last  = (r_idx == '0);

`ifdef SAR_CMP_PIPE_EN
    // Registered comparator: flags for the current trial are valid in WAIT.
    assign w_sample = (r_state == ST_WAIT);
`else
    assign w_sample = (r_state == ST_TRIAL);
`endif

    assign w_finish = w_sample & (~w_flag_ok | w_flags[AEB] | w_last);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_TRIAL;
                end
            end
            ST_TRIAL, ST_WAIT: begin
                if (w_sample) begin
                    w_state_next = w_finish ? ST_DONE : ST_TRIAL;
                end else if (r_state == ST_TRIAL) begin
                    // Only reached with the registered comparator.
                    w_state_next = ST_WAIT;
                end else begin
                    // WAIT without the registered comparator is unreachable;
                    // fall back to IDLE rather than lock up.
                    w_state_next = ST_IDLE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy  = (r_state == ST_TRIAL) || (r_state == ST_WAIT);
        done  = (r_state == ST_DONE);
        trial = busy ? w_trial : '0;
    end

    assign result = r_result;
    assign err    = r_err;

    // ------------------------------------------------------------------
    // Search datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_partial <= '0;
            r_result  <= '0;
            r_err     <= 1'b0;
        end else begin
            // err is only ever high for the single DONE cycle.
            r_err <= 1'b0;

            if ((r_state == ST_IDLE) && start) begin
                r_idx     <= IDX_W'(WIDTH - 1);
                r_partial <= '0;
            end else if (w_sample) begin
                if (!w_flag_ok) begin
                    // Bits decided so far are the best available answer.
                    r_result <= r_partial;
                    r_err    <= 1'b1;
                end else if (w_flags[AEB]) begin
                    r_result <= w_trial;
                end else begin
                    if (w_flags[AGB]) begin
                        r_partial <= w_trial;
                    end
                    if (w_last) begin
                        r_result <= w_flags[AGB] ? w_trial : r_partial;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
            end
        end
    end

endmodule : sar_search
`default_nettype wire

// File: tb/tb_sar_search.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_search
// Description : Self-checking bench for sar_search (WIDTH=4). A behavioural
//               comparator closes the loop (registered when SAR_CMP_PIPE_EN
//               is defined); its flags can be overridden to inject illegal
//               encodings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_search;

    localparam int W = 4;
`ifdef SAR_CMP_PIPE_EN
    localparam int L = 2;   // cycles per decision
`else
    localparam int L = 1;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         agb;
    logic         aeb;
    logic         alb;
    logic [W-1:0] trial;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err;

    logic [W-1:0] tval      = '0;
    logic         force_en  = 1'b0;
    logic [2:0]   force_val = 3'b000;
    logic [2:0]   cmp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef SAR_CMP_PIPE_EN
    always_ff @(posedge clk) begin
        cmp <= {tval > trial, tval == trial, tval < trial};
    end
`else
    always_comb begin
        cmp = {tval > trial, tval == trial, tval < trial};
    end
`endif

    always_comb begin
        {agb, aeb, alb} = force_en ? force_val : cmp;
    end

    sar_search #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .agb    (agb),
        .aeb    (aeb),
        .alb    (alb),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    // One full search. exp_tr packs the expected trial per decision, MSB
    // nibble first; force_dec>0 drives flags to 000 on that decision.
    task automatic run_search(input logic [3:0] t, input logic [15:0] exp_tr,
                              input int ntr, input logic [3:0] exp_res,
                              input int exp_edge, input logic exp_err,
                              input int force_dec, input string name);
        int          c;
        int          idx;
        logic [15:0] tr;
        logic [3:0]  e;
        tr   = exp_tr;
        tval = t;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;     // edge 0 accepted
        c = 0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_start got %b want 1", name, busy);
        end
        while (c < 40 && done !== 1'b1) begin
            idx = c / L;
            if (idx < ntr) begin
                e = tr[15-4*idx -: 4];
                checks++;
                if (trial !== e) begin
                    errors++;
                    $display("FAIL %s trial cycle %0d got %0d want %0d", name, c, trial, e);
                end
            end
            force_val = 3'b000;
            force_en  = (force_dec > 0) && (c == force_dec * L - 1);
            @(posedge clk); #1;
            force_en = 1'b0;
            c++;
        end
        checks++;
        if (c != exp_edge) begin
            errors++; $display("FAIL %s done_edge got %0d want %0d", name, c, exp_edge);
        end
        checks++;
        if (result !== exp_res) begin
            errors++; $display("FAIL %s result got %0d want %0d", name, result, exp_res);
        end
        checks++;
        if (err !== exp_err) begin
            errors++; $display("FAIL %s err got %b want %b", name, err, exp_err);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s busy_at_done got %b want 0", name, busy);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, err, busy} !== 3'b000) begin
            errors++; $display("FAIL %s idle_flags done/err/busy got %b want 000", name, {done, err, busy});
        end
        checks++;
        if (trial !== 4'd0) begin
            errors++; $display("FAIL %s idle_trial got %0d want 0", name, trial);
        end
        checks++;
        if (result !== exp_res) begin
            errors++; $display("FAIL %s result_hold got %0d want %0d", name, result, exp_res);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({trial, busy, done, result, err} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state trial=%0d busy=%b done=%b result=%0d err=%b want all 0",
                     trial, busy, done, result, err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_searches();
        run_search(4'd9,  16'h8CA9, 4, 4'd9,  4*L, 1'b0, 0, "t9");
        run_search(4'd0,  16'h8421, 4, 4'd0,  4*L, 1'b0, 0, "t0");
        run_search(4'd8,  16'h8000, 1, 4'd8,  1*L, 1'b0, 0, "t8_early");
        run_search(4'd15, 16'h8CEF, 4, 4'd15, 4*L, 1'b0, 0, "t15");
        run_search(4'd13, 16'h8CED, 4, 4'd13, 4*L, 1'b0, 0, "t13");
    endtask

    task automatic test_flag_error();
        run_search(4'd9, 16'h8C00, 2, 4'd8, 2*L, 1'b1, 2, "flags_000");
    endtask

    task automatic test_reset_mid();
        tval = 4'd5;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;     // edge 0
        @(posedge clk); #1;                  // edge 1
        #3 rst_n = 1'b0;                     // asserted before edge 2
        #1;
        checks++;
        if ({trial, busy, done, result, err} !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset trial=%0d busy=%b done=%b result=%0d err=%b want all 0",
                     trial, busy, done, result, err);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL mid_reset_hold done=%b busy=%b want 0 0", done, busy);
            end
        end
        rst_n = 1'b1;
        run_search(4'd5, 16'h8465, 4, 4'd5, 4*L, 1'b0, 0, "t5_after_reset");
    endtask

    // start held high throughout: ignored while busy and in DONE, accepted
    // at the first edge after the done cycle.
    task automatic test_back_to_back();
        int c;
        tval = 4'd6;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;                  // edge 0
        c = 0;
        while (c < 40 && done !== 1'b1) begin
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if (c != 3*L || result !== 4'd6) begin
            errors++; $display("FAIL b2b_first edge=%0d result=%0d want %0d 6", c, result, 3*L);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_idle busy=%b done=%b want 0 0", busy, done);
        end
        @(posedge clk); #1;
        start = 1'b0;
        tval  = 4'd3;
        checks++;
        if (busy !== 1'b1 || trial !== 4'd8) begin
            errors++; $display("FAIL b2b_restart busy=%b trial=%0d want 1 8", busy, trial);
        end
        c = 0;
        while (c < 40 && done !== 1'b1) begin
            @(posedge clk); #1;
            c++;
        end
        // T=3: 8 alb, 4 alb, 2 agb, 3 aeb
        checks++;
        if (c != 4*L || result !== 4'd3) begin
            errors++; $display("FAIL b2b_second edge=%0d result=%0d want %0d 3", c, result, 4*L);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_searches();
        test_flag_error();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sar_search
`default_nettype wire
